// File: rtl/perceptron_train_ctrl_if.sv
// -----------------------------------------------------------------------------
// perceptron_train_ctrl_if
// Bundles the sample handshake, configuration bus and result signals of
// perceptron_train_ctrl. clk and rst are kept outside as plain ports.
//   slave  : the perceptron block (drives in_ready, cfg_rdata, out_*, busy)
//   master : the block's user (drives in_*, cfg_we/addr/wdata)
// Parameters:
//   W_W   : signed weight/bias width
//   ACC_W : signed accumulator / out_sum width
// -----------------------------------------------------------------------------
interface perceptron_train_ctrl_if #(
  parameter int W_W   = 4,
  parameter int ACC_W = W_W + 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              in_data;
  logic                    in_label;
  logic                    in_train;
  logic                    cfg_we;
  logic [3:0]              cfg_addr;
  logic [W_W-1:0]          cfg_wdata;
  logic [W_W-1:0]          cfg_rdata;
  logic                    out_valid;
  logic                    out_class;
  logic signed [ACC_W-1:0] out_sum;
  logic                    out_updated;
  logic                    busy;

  modport slave (
    input  in_valid, in_data, in_label, in_train,
    input  cfg_we, cfg_addr, cfg_wdata,
    output in_ready, cfg_rdata,
    output out_valid, out_class, out_sum, out_updated, busy
  );

  modport master (
    output in_valid, in_data, in_label, in_train,
    output cfg_we, cfg_addr, cfg_wdata,
    input  in_ready, cfg_rdata,
    input  out_valid, out_class, out_sum, out_updated, busy
  );
endinterface

// File: rtl/perceptron_train_ctrl.sv
// -----------------------------------------------------------------------------
// perceptron_train_ctrl
// Single-neuron perceptron over an 8-bit binary feature vector with on-line
// perceptron-rule training. Eight weights and a bias are held in registers and
// are accessible through a small configuration port while the block is idle.
//
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous, active-high reset
//   bus : perceptron_train_ctrl_if.slave
//         in_valid/in_ready/in_data/in_label/in_train : sample handshake
//         cfg_we/cfg_addr/cfg_wdata/cfg_rdata          : weight/bias access
//                                                        (0-7 w[i], 8 bias)
//         out_valid/out_class/out_sum/out_updated      : result
//         busy                                         : state is not IDLE
//
// Timing: the accepting edge loads acc with the bias. The MAC state runs a
// two-stage select/accumulate pipeline: eight issue edges pick the addend for
// feature i, each addend is accumulated one edge later, so MAC spans nine
// edges. DECIDE then goes to DONE (10th edge) or via UPDATE (11th edge).
// -----------------------------------------------------------------------------
module perceptron_train_ctrl #(
  parameter int W_W   = 4,
  parameter int ACC_W = W_W + 4
) (
  input  logic                   clk,
  input  logic                   rst,
  perceptron_train_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MAC    = 3'd1,
    S_DECIDE = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic signed [W_W-1:0] W_MAX = {1'b0, {(W_W-1){1'b1}}};
  localparam logic signed [W_W-1:0] W_MIN = {1'b1, {(W_W-1){1'b0}}};
  localparam logic signed [W_W-1:0] W_ONE = {{(W_W-1){1'b0}}, 1'b1};

  // One perceptron-rule step (+1 when up, -1 otherwise), clamped to the
  // representable weight range.
  function automatic logic signed [W_W-1:0] sat_step(
    input logic signed [W_W-1:0] w,
    input logic                  up
  );
    if (up) begin
      return (w == W_MAX) ? w : w + W_ONE;
    end
    return (w == W_MIN) ? w : w - W_ONE;
  endfunction

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [W_W-1:0] w);
    return {{(ACC_W-W_W){w[W_W-1]}}, w};
  endfunction

  state_t                  r_state;
  state_t                  w_next;

  // Control
  logic [2:0]              r_idx;
  logic                    r_issue_done;
  logic                    r_vld_p0;

  // Weights and bias
  logic signed [W_W-1:0]   r_w [8];
  logic signed [W_W-1:0]   r_bias;

  // Sample and datapath
  logic [7:0]              r_data;
  logic                    r_label;
  logic                    r_train;
  logic signed [ACC_W-1:0] r_add_p0;
  logic signed [ACC_W-1:0] r_acc_p1;

  // Held results
  logic                    r_out_class;
  logic signed [ACC_W-1:0] r_out_sum;
  logic                    r_out_updated;

  logic                    w_in_ready;
  logic                    w_busy;
  logic                    w_out_valid;
  logic                    w_accept;
  logic                    w_cfg_wr;
  logic                    w_cls;
  logic [W_W-1:0]          w_rdata;

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_cfg_wr = bus.cfg_we && (r_state == S_IDLE) && (bus.cfg_addr <= 4'd8);
  // Inclusive threshold: a sum of exactly zero classifies as 1.
  assign w_cls    = ~r_acc_p1[ACC_W-1];

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_MAC;
      S_MAC:    if (r_issue_done) w_next = S_DECIDE;
      S_DECIDE: w_next = (r_train && (w_cls != r_label)) ? S_UPDATE : S_DONE;
      S_UPDATE: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM: outputs. A pending config write blocks sample acceptance.
  always_comb begin
    w_in_ready  = (r_state == S_IDLE) && !bus.cfg_we && !rst;
    w_busy      = (r_state != S_IDLE);
    w_out_valid = (r_state == S_DONE);
  end

  // MAC issue control: r_vld_p0 marks a valid addend in r_add_p0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= 3'd0;
      r_issue_done <= 1'b0;
      r_vld_p0     <= 1'b0;
    end else if (w_accept) begin
      r_idx        <= 3'd0;
      r_issue_done <= 1'b0;
      r_vld_p0     <= 1'b0;
    end else if (r_state == S_MAC) begin
      if (!r_issue_done) begin
        r_idx    <= r_idx + 3'd1;
        r_vld_p0 <= 1'b1;
        if (r_idx == 3'd7) r_issue_done <= 1'b1;
      end else begin
        r_vld_p0 <= 1'b0;
      end
    end
  end

  // Stage p0: addend select; stage p1: accumulate
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data   <= bus.in_data;
      r_label  <= bus.in_label;
      r_train  <= bus.in_train;
      r_acc_p1 <= sext(r_bias);
    end else if (r_state == S_MAC) begin
      if (!r_issue_done) begin
        r_add_p0 <= r_data[r_idx] ? sext(r_w[r_idx]) : '0;
      end
      if (r_vld_p0) begin
        r_acc_p1 <= r_acc_p1 + r_add_p0;
      end
    end
  end

  // Weight/bias storage: config writes in IDLE, perceptron step in UPDATE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_w[i] <= '0;
      r_bias <= '0;
    end else if (w_cfg_wr) begin
      if (bus.cfg_addr[3]) r_bias <= bus.cfg_wdata;
      else                 r_w[bus.cfg_addr[2:0]] <= bus.cfg_wdata;
    end else if (r_state == S_UPDATE) begin
      for (int i = 0; i < 8; i++) begin
        if (r_data[i]) r_w[i] <= sat_step(r_w[i], r_label);
      end
      r_bias <= sat_step(r_bias, r_label);
    end
  end

  // Results are captured on the transition into DONE and held afterwards.
  // acc is untouched by UPDATE, so the class seen there is still valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_class   <= 1'b0;
      r_out_sum     <= '0;
      r_out_updated <= 1'b0;
    end else if ((w_next == S_DONE) && (r_state != S_DONE)) begin
      r_out_class   <= w_cls;
      r_out_sum     <= r_acc_p1;
      r_out_updated <= (r_state == S_UPDATE);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.cfg_addr[3] == 1'b0) w_rdata = r_w[bus.cfg_addr[2:0]];
    else if (bus.cfg_addr == 4'd8) w_rdata = r_bias;
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.busy        = w_busy;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_class   = r_out_class;
  assign bus.out_sum     = r_out_sum;
  assign bus.out_updated = r_out_updated;
  assign bus.cfg_rdata   = w_rdata;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// -----------------------------------------------------------------------------
// tb_perceptron_train_ctrl
// Scoreboard bench for perceptron_train_ctrl (W_W=4, ACC_W=8). A reference
// model of weights/bias computes the expected result whenever a sample is
// accepted and queues it; a monitor pops and compares on every out_valid.
// -----------------------------------------------------------------------------
module tb_perceptron_train_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct {
    bit cls;
    int sum;
    bit upd;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   m_w [8];
  int   m_bias;

  perceptron_train_ctrl_if #(.W_W(4), .ACC_W(8)) bus ();

  perceptron_train_ctrl #(.W_W(4), .ACC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_s4(input logic [3:0] v);
    return (v > 4'd7) ? int'(v) - 16 : int'(v);
  endfunction

  function automatic int sat4(input int v);
    if (v > 7)  return 7;
    if (v < -8) return -8;
    return v;
  endfunction

  // Result monitor
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_class", int'(bus.out_class), int'(e.cls));
        check("out_sum", int'($signed(bus.out_sum)), e.sum);
        check("out_updated", int'(bus.out_updated), int'(e.upd));
        check("latency", cyc - e.acc, e.upd ? 11 : 10);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_w[i] = 0;
    m_bias = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    if (a < 4'd8)       m_w[a[2:0]] = to_s4(d);
    else if (a == 4'd8) m_bias = to_s4(d);
  endtask

  task automatic cfg_check(input string tag, input logic [3:0] a, input int exp);
    @(negedge clk);
    bus.cfg_addr = a;
    #1;
    check(tag, to_s4(bus.cfg_rdata), exp);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 9; i++) begin
      logic [3:0] a;
      a = 4'(i);
      cfg_check(tag, a, (i < 8) ? m_w[i] : m_bias);
    end
    cfg_check({tag, "_unmapped"}, 4'd12, 0);
  endtask

  // Offers one sample for one cycle; queues the model result if accepted.
  task automatic send(input logic [7:0] d, input bit lbl, input bit trn);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_label = lbl;
    bus.in_train = trn;
    #1;
    check("in_ready_idle", int'(bus.in_ready), 1);
    if (bus.in_ready) begin
      e.sum = m_bias;
      for (int i = 0; i < 8; i++) if (d[i]) e.sum += m_w[i];
      e.cls = (e.sum >= 0);
      e.upd = trn && (e.cls != lbl);
      e.acc = cyc + 1;
      if (e.upd) begin
        for (int i = 0; i < 8; i++) if (d[i]) m_w[i] = sat4(m_w[i] + (lbl ? 1 : -1));
        m_bias = sat4(m_bias + (lbl ? 1 : -1));
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("idle_timeout", 1, 0);
      sb.delete();
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_label  = 1'b0;
    bus.in_train  = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_class", int'(bus.out_class), 0);
    check("rst_out_sum", int'($signed(bus.out_sum)), 0);
    check("rst_out_updated", int'(bus.out_updated), 0);
    rst = 1'b0;
    check_all_regs("rst_rd");

    // Zero-weight inference
    send(8'hFF, 1'b0, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("hold_class", int'(bus.out_class), 1);

    // Threshold around zero
    for (int i = 0; i < 8; i++) cfg_write(4'(i), 4'h1);
    cfg_write(4'd8, 4'hD);
    send(8'h03, 1'b0, 1'b0);
    wait_idle();
    send(8'h07, 1'b0, 1'b0);
    wait_idle();
    check_all_regs("thr_rd");

    // Training step from zero weights
    do_reset();
    send(8'h05, 1'b0, 1'b1);
    wait_idle();
    check_all_regs("train_rd");

    // Negative saturation
    do_reset();
    cfg_write(4'd0, 4'h8);
    cfg_write(4'd1, 4'h7);
    cfg_write(4'd2, 4'h7);
    cfg_write(4'd9, 4'h5);
    send(8'h07, 1'b0, 1'b1);
    wait_idle();
    check_all_regs("satn_rd");

    // Positive saturation
    cfg_write(4'd0, 4'h7);
    cfg_write(4'd8, 4'h8);
    send(8'h01, 1'b1, 1'b1);
    wait_idle();
    check_all_regs("satp_rd");

    // Collisions: cfg_we during MAC, in_valid while busy
    send(8'hAA, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'd1;
    bus.cfg_wdata = 4'h5;
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      #1 check("busy_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    wait_idle();
    check_all_regs("coll_rd");

    // cfg_we together with in_valid in IDLE
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'd3;
    bus.cfg_wdata = 4'h6;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h08;
    #1 check("cfg_pri_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    bus.cfg_we   = 1'b0;
    bus.in_valid = 1'b0;
    m_w[3] = 6;
    @(negedge clk);
    check("cfg_pri_busy", int'(bus.busy), 0);
    cfg_check("cfg_pri_rd", 4'd3, 6);

    // Random training sequence
    for (int n = 0; n < 24; n++) begin
      if (n % 8 == 0) begin
        for (int i = 0; i < 9; i++) cfg_write(4'(i), 4'($urandom_range(0, 15)));
      end
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_idle();
    end
    check_all_regs("rand_rd");

    // Reset during MAC
    cfg_write(4'd4, 4'h5);
    send(8'h10, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_in_ready", int'(bus.in_ready), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all_regs("midrst_rd");
    repeat (15) @(negedge clk);
    send(8'hFF, 1'b1, 1'b1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
